// File: rtl/elbeth_fetch_unit.sv
// ELBETH instruction-fetch stage with IF/ID register: PC, req/ready fetch,
// ID redirect with wrong-path squash, and halt on misaligned redirect target.
module elbeth_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_branch,
   input  logic        branch_taken,
   input  logic        id_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        imem_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instruction,
   output logic        if_valid,
   output logic        if_misaligned
);

   // state   | meaning
   // S_BOOT  | one idle cycle after reset release, no fetch
   // S_FETCH | fetching; IF/ID updated per stall/redirect/ready priority
   // S_HALT  | misaligned redirect taken; frozen until reset
   typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HALT} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] if_pc_n, if_instruction_n;
   logic        if_valid_n, if_misaligned_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_BOOT;
         pc             <= RESET_PC;
         if_pc          <= 32'h0000_0000;
         if_instruction <= NOP_INSTR;
         if_valid       <= 1'b0;
         if_misaligned  <= 1'b0;
      end else begin
         state          <= state_n;
         pc             <= pc_n;
         if_pc          <= if_pc_n;
         if_instruction <= if_instruction_n;
         if_valid       <= if_valid_n;
         if_misaligned  <= if_misaligned_n;
      end
   end

   always_comb begin
      state_n          = state;
      pc_n             = pc;
      if_pc_n          = if_pc;
      if_instruction_n = if_instruction;
      if_valid_n       = if_valid;
      if_misaligned_n  = if_misaligned;
      imem_req         = 1'b0;
      case (state)
         S_BOOT: state_n = S_FETCH;
         S_FETCH: begin
            imem_req = ~id_stall;
            // A stall masks the redirect: ID re-resolves the branch on release.
            if (id_stall) begin
               state_n = S_FETCH;
            end else if (branch_taken) begin
               pc_n             = pc_branch;
               if_valid_n       = 1'b0;
               if_instruction_n = NOP_INSTR;
               if (pc_branch[1:0] != 2'b00) begin
                  if_misaligned_n = 1'b1;
                  state_n         = S_HALT;
               end
            end else if (imem_ready) begin
               if_instruction_n = imem_data;
               if_pc_n          = pc;
               if_valid_n       = 1'b1;
               pc_n             = pc + 32'd4;
            end else begin
               if_valid_n       = 1'b0;
               if_instruction_n = NOP_INSTR;
            end
         end
         S_HALT: if_valid_n = 1'b0;
         default: state_n = S_BOOT;
      endcase
   end

   assign imem_addr = pc;

endmodule

// File: tb/tb_elbeth_fetch_unit.sv
// Bench for elbeth_fetch_unit: directed vector table plus randomized traffic
// checked against a rule-level reference model of the fetch stage.
module tb_elbeth_fetch_unit;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] MASK = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc_branch = '0;
   logic        branch_taken = 1'b0;
   logic        id_stall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        imem_ready = 1'b0;
   logic [31:0] if_pc;
   logic [31:0] if_instruction;
   logic        if_valid;
   logic        if_misaligned;

   int errors = 0;
   int checks = 0;

   elbeth_fetch_unit dut (
      .clk(clk), .rst(rst), .pc_branch(pc_branch), .branch_taken(branch_taken),
      .id_stall(id_stall), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_data(imem_data), .imem_ready(imem_ready), .if_pc(if_pc),
      .if_instruction(if_instruction), .if_valid(if_valid),
      .if_misaligned(if_misaligned)
   );

   always #5 clk = ~clk;

   // memory: every word holds its own address scrambled
   assign imem_data = imem_addr ^ MASK;

   // reference model: fetch stage described as a set of plain facts
   bit          m_booted, m_halted, m_valid, m_mis;
   logic [31:0] m_pc, m_if_pc, m_instr;

   typedef struct {
      bit          stl;
      bit          br;
      logic [31:0] tgt;
      bit          rdy;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_valid;
      logic [31:0] e_pc;
      bit          e_mis;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_booted = 0; m_halted = 0; m_valid = 0; m_mis = 0;
      m_pc = 32'h0; m_if_pc = 32'h0; m_instr = NOP;
   endtask

   task automatic model_edge(input bit stl, input bit br, input logic [31:0] tgt, input bit rdy);
      if (!m_booted) m_booted = 1;
      else if (m_halted) m_valid = 0;
      else if (stl) begin end
      else if (br) begin
         m_pc = tgt; m_valid = 0; m_instr = NOP;
         if (tgt % 4 != 0) begin m_mis = 1; m_halted = 1; end
      end else if (rdy) begin
         m_if_pc = m_pc; m_instr = m_pc ^ MASK; m_valid = 1; m_pc = m_pc + 4;
      end else begin
         m_valid = 0; m_instr = NOP;
      end
   endtask

   task automatic check_reset_values();
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_instr", if_instruction, NOP);
      chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
      chk("rst_if_mis", {31'b0, if_misaligned}, 32'h0);
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
   endtask

   // assert reset mid-cycle, check asynchronous effect, release just after an edge
   task automatic do_reset();
      #3 rst = 1'b1;
      #1 model_reset();
      check_reset_values();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // one clock: drive, check fetch request, take edge, check IF/ID
   task automatic step(input vec_t v, input bit use_tbl);
      id_stall = v.stl; branch_taken = v.br; pc_branch = v.tgt; imem_ready = v.rdy;
      #1;
      chk("m_req", {31'b0, imem_req}, {31'b0, m_booted && !m_halted && !v.stl});
      chk("m_addr", imem_addr, m_pc);
      if (use_tbl) begin
         chk("t_req", {31'b0, imem_req}, {31'b0, v.e_req});
         chk("t_addr", imem_addr, v.e_addr);
      end
      @(posedge clk);
      model_edge(v.stl, v.br, v.tgt, v.rdy);
      #1;
      chk("m_valid", {31'b0, if_valid}, {31'b0, m_valid});
      chk("m_mis", {31'b0, if_misaligned}, {31'b0, m_mis});
      chk("m_instr", if_instruction, m_instr);
      if (m_valid) chk("m_if_pc", if_pc, m_if_pc);
      if (use_tbl) begin
         chk("t_valid", {31'b0, if_valid}, {31'b0, v.e_valid});
         chk("t_mis", {31'b0, if_misaligned}, {31'b0, v.e_mis});
         chk("t_if_pc", if_pc, v.e_pc);
         chk("t_instr", if_instruction, v.e_valid ? (v.e_pc ^ MASK) : NOP);
      end
   endtask

   task automatic add(input bit stl, input bit br, input logic [31:0] tgt, input bit rdy,
                      input bit e_req, input logic [31:0] e_addr, input bit e_valid,
                      input logic [31:0] e_pc, input bit e_mis);
      vec_t v;
      v.stl = stl; v.br = br; v.tgt = tgt; v.rdy = rdy; v.e_req = e_req;
      v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_mis = e_mis;
      vecs.push_back(v);
   endtask

   initial begin
      //   stl br tgt            rdy req addr           valid if_pc          mis
      add(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         0); // boot idle
      add(0, 0, 32'h0,         1, 1, 32'h0,         1, 32'h0,         0);
      add(0, 0, 32'h0,         1, 1, 32'h4,         1, 32'h4,         0);
      add(0, 0, 32'h0,         1, 1, 32'h8,         1, 32'h8,         0);
      add(0, 1, 32'h100,       1, 1, 32'hC,         0, 32'h8,         0); // redirect, data dropped
      add(0, 0, 32'h0,         1, 1, 32'h100,       1, 32'h100,       0);
      add(0, 0, 32'h0,         1, 1, 32'h104,       1, 32'h104,       0);
      add(0, 1, 32'h10,        1, 1, 32'h108,       0, 32'h104,       0);
      add(0, 0, 32'h0,         0, 1, 32'h10,        0, 32'h104,       0); // memory wait x3
      add(0, 0, 32'h0,         0, 1, 32'h10,        0, 32'h104,       0);
      add(0, 0, 32'h0,         0, 1, 32'h10,        0, 32'h104,       0);
      add(0, 0, 32'h0,         1, 1, 32'h10,        1, 32'h10,        0);
      add(1, 1, 32'h200,       1, 0, 32'h14,        1, 32'h10,        0); // stall beats branch
      add(1, 1, 32'h200,       1, 0, 32'h14,        1, 32'h10,        0);
      add(0, 0, 32'h0,         1, 1, 32'h14,        1, 32'h14,        0);
      add(0, 1, 32'hFFFF_FFFC, 1, 1, 32'h18,        0, 32'h14,        0); // wrap
      add(0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0);
      add(0, 0, 32'h0,         1, 1, 32'h0,         1, 32'h0,         0);
      add(0, 1, 32'h102,       1, 1, 32'h4,         0, 32'h0,         1); // misaligned -> halt
      add(0, 0, 32'h0,         1, 0, 32'h102,       0, 32'h0,         1);
      add(0, 1, 32'h40,        1, 0, 32'h102,       0, 32'h0,         1);

      do_reset();
      foreach (vecs[i]) step(vecs[i], 1'b1);
      do_reset();  // out of S_HALT

      // memory wait, then reset in the middle of the wait
      begin
         vec_t v;
         v = '{stl:0, br:0, tgt:32'h0, rdy:1, e_req:0, e_addr:0, e_valid:0, e_pc:0, e_mis:0};
         step(v, 1'b0); step(v, 1'b0);
         v.rdy = 0;
         step(v, 1'b0); step(v, 1'b0);
         do_reset();
      end

      for (int n = 0; n < 600; n++) begin
         vec_t v;
         v.stl = ($urandom_range(0, 99) < 20);
         v.br  = ($urandom_range(0, 99) < 12);
         v.tgt = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 9) == 0) v.tgt = 32'hFFFF_FFF8;
         if ($urandom_range(0, 99) < 4) v.tgt[1:0] = 2'($urandom_range(1, 3));
         v.rdy = ($urandom_range(0, 99) < 70);
         v.e_req = 0; v.e_addr = 0; v.e_valid = 0; v.e_pc = 0; v.e_mis = 0;
         step(v, 1'b0);
         if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
            do_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/elbeth_fetch_unit.md
Name: elbeth_fetch_unit

Overview:
Instruction-fetch stage of the ELBETH pipeline, including the IF/ID pipeline register.
- Holds the PC and issues word fetches to instruction memory over a req/ready handshake.
- Registers each returned instruction with its PC for the decode stage.
- Consumes the redirect (pc_branch, branch_taken) resolved in ID and squashes the wrong-path fetch.
- Halts on a misaligned redirect target.

Parameters:
RESET_PC, 32'h00000000, PC loaded on reset.
NOP_INSTR, 32'h00000013, value driven on if_instruction when no valid instruction is present (addi x0,x0,0).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
pc_branch  input  32  redirect target from the ID branch unit.
branch_taken  input  1  redirect request from the ID branch unit; sampled at the clk edge.
id_stall  input  1  hazard stall from decode; freezes PC and IF/ID.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address; always equals the current PC.
imem_data  input  32  fetched word; valid only in a cycle where imem_req and imem_ready are both 1.
imem_ready  input  1  memory completes the request this cycle.
if_pc  output  32  PC of the instruction in IF/ID.
if_instruction  output  32  instruction in IF/ID.
if_valid  output  1  IF/ID holds a real instruction.
if_misaligned  output  1  sticky; a redirect target with pc_branch[1:0] != 0 was taken.

Behaviour:
Reset (asynchronous, immediate):
- state=S_BOOT, pc=RESET_PC.
- if_pc=0, if_instruction=NOP_INSTR, if_valid=0, if_misaligned=0.
- imem_req=0.

State machine:
- S_BOOT: imem_req=0. Next state is S_FETCH unconditionally; one idle cycle after reset deassertion.
- S_FETCH: imem_req = ~id_stall.
- S_HALT: imem_req=0, if_valid=0, pc frozen. Only rst exits this state.

S_FETCH per-edge actions, evaluated in strict priority order:
1. id_stall=1: pc, if_pc, if_instruction and if_valid all hold. branch_taken is ignored, because ID re-evaluates the branch when the stall releases.
2. branch_taken=1 with pc_branch[1:0]==0:
   - pc<=pc_branch, if_valid<=0, if_instruction<=NOP_INSTR.
   - Any imem response in this cycle is discarded as wrong-path.
3. branch_taken=1 with pc_branch[1:0]!=0:
   - if_misaligned<=1, if_valid<=0, state<=S_HALT.
   - pc<=pc_branch, kept for debug.
4. imem_ready=1: if_instruction<=imem_data, if_pc<=pc, if_valid<=1, pc<=pc+4.
5. Otherwise (memory wait): if_valid<=0 (bubble), if_instruction<=NOP_INSTR, pc holds, imem_req stays 1.

Arithmetic and timing:
- pc+4 is modulo 2^32: 32'hFFFFFFFC wraps to 32'h00000000 with no flag.
- imem_addr is combinational from the pc register; no other output is combinational.
- Latency: with imem_ready tied to 1, one instruction per cycle, and if_valid rises on the second edge after reset deassertion.
- Redirect penalty: exactly one bubble cycle. if_valid=0 for the cycle after the redirect edge; the target instruction appears the cycle after that when ready=1.

Boundary conditions:
- Simultaneous branch_taken and imem_ready: the redirect wins and the data is dropped.
- Simultaneous id_stall and imem_ready: the data is dropped and the same PC is re-fetched after the stall.
- Reset asserted mid-wait or in S_HALT: immediate return to the reset values; any outstanding memory response is ignored (imem_req=0 during reset).

Test Plan:
- Reset release with imem_ready=1 and memory returning addr^32'hA5A5A5A5: if_valid rises at cycle 2; if_pc sequence is 0,4,8,... with matching data and no gaps.
- Redirect: at if_pc=8, pulse branch_taken with pc_branch=32'h100. Expect one cycle with if_valid=0 and NOP_INSTR, then if_pc=32'h100, then 32'h104.
- Memory wait: hold imem_ready=0 for 3 cycles at pc=32'h10. Expect imem_addr held at 32'h10, if_valid=0 for 3 cycles, then if_pc=32'h10 with the correct data.
- Stall priority: assert id_stall for 2 cycles together with branch_taken=1 and imem_ready=1. Expect IF/ID and pc unchanged and imem_req=0; after release, the next fetch is the same PC.
- Misaligned redirect to pc_branch=32'h102: if_misaligned=1, state S_HALT, imem_req=0 indefinitely. Asserting rst mid-cycle clears everything asynchronously.
- Wrap: redirect to 32'hFFFFFFFC with ready=1. Expect if_pc=32'hFFFFFFFC, then 32'h00000000.
